// File: rtl/memory_mapped_io_uart_rx_if.sv
// CPU-side MMIO bus shared by the UART RX block: command strobe, address,
// write data and registered read data.
interface memory_mapped_io_uart_rx_if;
    logic        input_cmd_start;
    logic        input_cmd_write;
    logic        output_cmd_ready;
    logic [31:0] input_addr;
    logic [31:0] output_rdata;
    logic        output_rdata_valid;
    logic [31:0] input_wdata;

    modport master (
        output input_cmd_start, input_cmd_write, input_addr, input_wdata,
        input  output_cmd_ready, output_rdata, output_rdata_valid
    );

    modport slave (
        input  input_cmd_start, input_cmd_write, input_addr, input_wdata,
        output output_cmd_ready, output_rdata, output_rdata_valid
    );
endinterface

// File: rtl/memory_mapped_io_uart_rx.sv
// UART 8N1 receiver feeding a 256-byte circular queue.
// The CPU polls the queue and its status through a simple MMIO bus.
module memory_mapped_io_uart_rx #(
    parameter int unsigned FMAX_MHz          = 27,
    parameter int unsigned BAUD              = 115200,
    parameter logic [31:0] QUEUE_HEAD_OFFSET = 32'h100,
    parameter logic [31:0] QUEUE_TAIL_OFFSET = 32'h104,
    parameter logic [31:0] STATUS_OFFSET     = 32'h108
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    memory_mapped_io_uart_rx_if.slave     bus
);

    localparam int unsigned CLKS_PER_BIT = FMAX_MHz * 1000000 / BAUD;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             ferr_set;

    logic [7:0]       head_q, head_d;
    logic [7:0]       tail_q, tail_d;
    logic             overflow_q, overflow_d;
    logic             framing_err_q, framing_err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mem_we;
    logic             queue_full;
    logic             head_wr, status_wr;

    logic [31:0]      buf_mem [64];

    assign bus.output_cmd_ready   = 1'b1;
    assign bus.output_rdata_valid = 1'b1;
    assign bus.output_rdata       = rdata_q;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_sync_q) push_d   = 1'b1;
                    else           ferr_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Full check sees the pre-write head; shift_q holds the byte until the next frame's DATA phase.
    assign queue_full = (tail_q + 8'd1) == head_q;
    assign head_wr    = bus.input_cmd_start && bus.input_cmd_write && (bus.input_addr == QUEUE_HEAD_OFFSET);
    assign status_wr  = bus.input_cmd_start && bus.input_cmd_write && (bus.input_addr == STATUS_OFFSET);

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        overflow_d    = overflow_q;
        framing_err_d = framing_err_q;
        mem_we        = 1'b0;
        rdata_d       = rdata_q;

        if (status_wr) begin
            if (bus.input_wdata[0]) overflow_d    = 1'b0;
            if (bus.input_wdata[1]) framing_err_d = 1'b0;
        end
        if (ferr_set) framing_err_d = 1'b1;
        if (push_q) begin
            if (queue_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                tail_d = tail_q + 8'd1;
            end
        end
        if (head_wr) head_d = bus.input_wdata[7:0];

        if (bus.input_cmd_start) begin
            if (bus.input_addr < 32'h100)                 rdata_d = buf_mem[bus.input_addr[7:2]];
            else if (bus.input_addr == QUEUE_HEAD_OFFSET) rdata_d = {24'b0, head_q};
            else if (bus.input_addr == QUEUE_TAIL_OFFSET) rdata_d = {24'b0, tail_q};
            else if (bus.input_addr == STATUS_OFFSET)
                rdata_d = {29'b0, head_q != tail_q, framing_err_q, overflow_q};
            else                                          rdata_d = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            overflow_q    <= 1'b0;
            framing_err_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rx_meta_q     <= uart_rx;
            rx_sync_q     <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            push_q        <= push_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            overflow_q    <= overflow_d;
            framing_err_q <= framing_err_d;
            rdata_q       <= rdata_d;
        end
    end

    // NOTE: the buffer RAM has no reset so it maps onto block RAM; unwritten bytes are don't-care.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (tail_q[1:0])
                2'd0: buf_mem[tail_q[7:2]][7:0]   <= shift_q;
                2'd1: buf_mem[tail_q[7:2]][15:8]  <= shift_q;
                2'd2: buf_mem[tail_q[7:2]][23:16] <= shift_q;
                default: buf_mem[tail_q[7:2]][31:24] <= shift_q;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_mapped_io_uart_rx.sv
// Directed bench for the MMIO UART receiver, run with a short bit period
// (8 clocks per bit) so the 256-byte overflow scenario stays brief.
module tb_memory_mapped_io_uart_rx;

    localparam int unsigned FMAX = 1;
    localparam int unsigned BAUD = 125000;
    localparam int          CPB  = 8;
    localparam logic [31:0] HEAD_A = 32'h100;
    localparam logic [31:0] TAIL_A = 32'h104;
    localparam logic [31:0] STAT_A = 32'h108;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    logic [31:0] rd;

    memory_mapped_io_uart_rx_if bus ();

    memory_mapped_io_uart_rx #(
        .FMAX_MHz(FMAX),
        .BAUD    (BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.input_cmd_start = 1'b1;
        bus.input_cmd_write = 1'b0;
        bus.input_addr      = a;
        @(negedge clk);
        bus.input_cmd_start = 1'b0;
        d = bus.output_rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        bus.input_cmd_start = 1'b1;
        bus.input_cmd_write = 1'b1;
        bus.input_addr      = a;
        bus.input_wdata     = w;
        @(negedge clk);
        bus.input_cmd_start = 1'b0;
        bus.input_cmd_write = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        bus.input_cmd_start = 1'b0;
        bus.input_cmd_write = 1'b0;
        bus.input_addr      = '0;
        bus.input_wdata     = '0;

        // 1: reset state, then a single byte
        do_reset();
        check("rdata_after_reset", bus.output_rdata, 32'h0);
        check("cmd_ready", {31'b0, bus.output_cmd_ready}, 32'h1);
        check("rdata_valid", {31'b0, bus.output_rdata_valid}, 32'h1);
        bus_read(STAT_A, rd); check("t1_status_reset", rd, 32'h0);
        bus_read(TAIL_A, rd); check("t1_tail_reset", rd, 32'h0);
        send_frame(8'h41, 1'b1);
        bus_read(TAIL_A, rd); check("t1_tail", rd, 32'h1);
        bus_read(32'h0, rd);  check("t1_buf0_lane0", rd & 32'hff, 32'h41);
        bus_read(STAT_A, rd); check("t1_status", rd, 32'h4);

        // 2: "ABCDE", head consume, ignored writes, unmapped read
        do_reset();
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h45, 1'b1);
        bus_read(TAIL_A, rd); check("t2_tail", rd, 32'h5);
        bus_read(32'h0, rd);  check("t2_word0", rd, 32'h44434241);
        bus_read(32'h4, rd);  check("t2_word1_lane0", rd & 32'hff, 32'h45);
        bus_write(TAIL_A, 32'h99);
        bus_read(TAIL_A, rd); check("t2_tail_ro", rd, 32'h5);
        bus_read(32'h10C, rd); check("t2_unmapped", rd, 32'h0);
        bus_write(HEAD_A, 32'h5);
        bus_read(HEAD_A, rd); check("t2_head", rd, 32'h5);
        bus_read(STAT_A, rd); check("t2_status_empty", rd, 32'h0);

        // 3: short low glitch is rejected, receiver still works afterwards
        do_reset();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bus_read(TAIL_A, rd); check("t3_tail", rd, 32'h0);
        bus_read(STAT_A, rd); check("t3_status", rd, 32'h0);
        send_frame(8'hA5, 1'b1);
        bus_read(32'h0, rd);  check("t3_after_glitch", rd & 32'hff, 32'hA5);

        // 4: framing error, then W1C
        do_reset();
        send_frame(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        bus_read(TAIL_A, rd); check("t4_tail", rd, 32'h0);
        bus_read(STAT_A, rd); check("t4_status_ferr", rd, 32'h2);
        bus_write(STAT_A, 32'h2);
        bus_read(STAT_A, rd); check("t4_status_clr", rd, 32'h0);

        // 5: fill to 255, overflow on byte 256, then wrap
        do_reset();
        for (int i = 0; i < 255; i++) send_frame(8'(i), 1'b1);
        bus_read(STAT_A, rd); check("t5_status_full", rd, 32'h4);
        send_frame(8'hFF, 1'b1);
        bus_read(TAIL_A, rd); check("t5_tail_full", rd, 32'hFF);
        bus_read(STAT_A, rd); check("t5_status_ovf", rd, 32'h5);
        bus_read(32'h0, rd);  check("t5_word0", rd, 32'h03020100);
        bus_read(32'hFC, rd); check("t5_word63_low", rd & 32'h00ffffff, 32'h00FEFDFC);
        bus_write(HEAD_A, 32'hFF);
        send_frame(8'h7E, 1'b1);
        bus_read(TAIL_A, rd); check("t5_tail_wrap", rd, 32'h0);
        bus_read(32'hFC, rd); check("t5_word63", rd, 32'h7EFEFDFC);
        bus_write(STAT_A, 32'h1);
        bus_read(STAT_A, rd); check("t5_status_ovf_clr", rd, 32'h4);

        // 6: reset in the middle of DATA aborts the frame
        do_reset();
        bus_read(32'h10C, rd);
        bus_write(HEAD_A, 32'h3);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rdata_in_reset", bus.output_rdata, 32'h0);
        rst_n = 1'b1;
        repeat (6 * CPB) @(negedge clk);
        bus_read(HEAD_A, rd); check("t6_head", rd, 32'h0);
        bus_read(TAIL_A, rd); check("t6_tail", rd, 32'h0);
        bus_read(STAT_A, rd); check("t6_status", rd, 32'h0);
        send_frame(8'h3C, 1'b1);
        bus_read(TAIL_A, rd); check("t6_tail_next", rd, 32'h1);
        bus_read(32'h0, rd);  check("t6_byte_next", rd & 32'hff, 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
